// File: rtl/issue_scoreboard.sv
// Issue stage: per-register pending/countdown scoreboard plus multiplier busy counter; issues one instr/cycle, is_ex_* registered (1 cycle).
// Backpressure: RAW/WAW/mul-busy hazards or execute_stall raise is_if_stall; execute_stall also freezes all state and is_ex_*.
module issue_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int CW      = 3,
    parameter int LAT_ALU = 1,
    parameter int LAT_MEM = 2,
    parameter int LAT_MUL = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_is_valid,
    input  logic [AW-1:0]   id_is_addra,
    input  logic [AW-1:0]   id_is_addrb,
    input  logic [1:0]      id_is_numop,
    input  logic [AW-1:0]   id_is_regdest,
    input  logic            id_is_writereg,
    input  logic [1:0]      id_is_fu,
    input  logic            execute_stall,
    output logic            is_if_stall,
    output logic            is_ex_valid,
    output logic [1:0]      is_ex_unidadefuncional,
    output logic [AW-1:0]   is_ex_regdest,
    output logic            is_ex_writereg,
    output logic [NREG-1:0] is_pending
);

    localparam logic [1:0] FU_NONE = 2'b00;
    localparam logic [1:0] FU_ALU  = 2'b01;
    localparam logic [1:0] FU_MEM  = 2'b10;
    localparam logic [1:0] FU_MUL  = 2'b11;

    logic [NREG-1:0] pending;
    logic [CW-1:0]   count [NREG];
    logic [CW-1:0]   mulbusy;

    logic [NREG-1:0] pend_v;
    logic            wr_eff;
    logic            raw_a;
    logic            raw_b;
    logic            waw;
    logic            struct_haz;
    logic            hazard;
    logic            issue;
    logic [CW-1:0]   lat_sel;

    // Register 0 is hardwired: it can never block a reader or writer.
    assign pend_v     = {pending[NREG-1:1], 1'b0};
    assign wr_eff     = id_is_writereg & (id_is_fu != FU_NONE);
    assign raw_a      = (id_is_numop != 2'd0) & pend_v[id_is_addra];
    assign raw_b      = id_is_numop[1] & pend_v[id_is_addrb];
    assign waw        = wr_eff & pend_v[id_is_regdest];
    assign struct_haz = (id_is_fu == FU_MUL) & (mulbusy != '0);
    assign hazard     = id_is_valid & (raw_a | raw_b | waw | struct_haz);
    assign is_if_stall = ~reset & (hazard | execute_stall);
    assign issue      = id_is_valid & ~hazard & ~execute_stall;
    assign is_pending = pending;

    always_comb begin
        lat_sel = '0;
        case (id_is_fu)
            FU_ALU:  lat_sel = CW'(LAT_ALU);
            FU_MEM:  lat_sel = CW'(LAT_MEM);
            FU_MUL:  lat_sel = CW'(LAT_MUL);
            default: lat_sel = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending                <= '0;
            mulbusy                <= '0;
            is_ex_valid            <= 1'b0;
            is_ex_unidadefuncional <= FU_NONE;
            is_ex_regdest          <= '0;
            is_ex_writereg         <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                count[i] <= '0;
            end
        end else if (!execute_stall) begin
            for (int i = 0; i < NREG; i++) begin
                if (pending[i]) begin
                    if (count[i] > CW'(1)) begin
                        count[i] <= count[i] - 1'b1;
                    end else begin
                        pending[i] <= 1'b0;
                        count[i]   <= '0;
                    end
                end
            end
            if (mulbusy != '0) begin
                mulbusy <= mulbusy - 1'b1;
            end
            // Issue assignments come last so they override the countdown
            // (a newly set register/mul cannot also be counting down).
            if (issue) begin
                is_ex_valid            <= 1'b1;
                is_ex_unidadefuncional <= id_is_fu;
                is_ex_regdest          <= id_is_regdest;
                is_ex_writereg         <= wr_eff;
                if (wr_eff && (id_is_regdest != '0)) begin
                    pending[id_is_regdest] <= 1'b1;
                    count[id_is_regdest]   <= lat_sel;
                end
                if (id_is_fu == FU_MUL) begin
                    mulbusy <= CW'(LAT_MUL);
                end
            end else begin
                is_ex_valid            <= 1'b0;
                is_ex_unidadefuncional <= FU_NONE;
                is_ex_regdest          <= '0;
                is_ex_writereg         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stall-cycle counts checked inline, issued instructions checked by a queue monitor.
module tb_issue_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [1:0]    fu;
        logic [AW-1:0] rd;
        logic          wr;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            id_is_valid;
    logic [AW-1:0]   id_is_addra;
    logic [AW-1:0]   id_is_addrb;
    logic [1:0]      id_is_numop;
    logic [AW-1:0]   id_is_regdest;
    logic            id_is_writereg;
    logic [1:0]      id_is_fu;
    logic            execute_stall;
    logic            is_if_stall;
    logic            is_ex_valid;
    logic [1:0]      is_ex_unidadefuncional;
    logic [AW-1:0]   is_ex_regdest;
    logic            is_ex_writereg;
    logic [NREG-1:0] is_pending;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic froze;

    issue_scoreboard #(
        .NREG(NREG), .AW(AW), .CW(3), .LAT_ALU(1), .LAT_MEM(2), .LAT_MUL(4)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .id_is_valid            (id_is_valid),
        .id_is_addra            (id_is_addra),
        .id_is_addrb            (id_is_addrb),
        .id_is_numop            (id_is_numop),
        .id_is_regdest          (id_is_regdest),
        .id_is_writereg         (id_is_writereg),
        .id_is_fu               (id_is_fu),
        .execute_stall          (execute_stall),
        .is_if_stall            (is_if_stall),
        .is_ex_valid            (is_ex_valid),
        .is_ex_unidadefuncional (is_ex_unidadefuncional),
        .is_ex_regdest          (is_ex_regdest),
        .is_ex_writereg         (is_ex_writereg),
        .is_pending             (is_pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one instruction and queue the response execute must see.
    task automatic present(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [1:0] numop,
                           input logic [AW-1:0] rd, input logic wr, input logic [1:0] fu,
                           input logic exp_wr);
        exp_t e;
        id_is_valid    = 1'b1;
        id_is_addra    = a;
        id_is_addrb    = b;
        id_is_numop    = numop;
        id_is_regdest  = rd;
        id_is_writereg = wr;
        id_is_fu       = fu;
        e.fu = fu;
        e.rd = rd;
        e.wr = exp_wr;
        exp_q.push_back(e);
    endtask

    // Count stalled cycles until the presented instruction issues; returns just after the issuing edge.
    task automatic wait_issue(input string name, input int exp_stalls);
        int stalls;
        bit ok;
        stalls = 0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!is_if_stall) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clock); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no issue within 20 cycles, stalls=%0d expected %0d", name, stalls, exp_stalls);
            void'(exp_q.pop_back());
            id_is_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        id_is_valid = 1'b0;
        check(name, stalls, exp_stalls);
    endtask

    // Monitor: every non-frozen cycle is either a queued issue or a clean bubble.
    always begin
        exp_t e;
        @(posedge clock);
        froze = execute_stall | reset;
        @(negedge clock);
        if (!reset && !froze) begin
            if (is_ex_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: got issue fu=%0h rd=%0d required none", is_ex_unidadefuncional, is_ex_regdest);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_fu", 32'(is_ex_unidadefuncional), 32'(e.fu));
                    check("mon_rd", 32'(is_ex_regdest), 32'(e.rd));
                    check("mon_wr", 32'(is_ex_writereg), 32'(e.wr));
                end
            end else begin
                check("mon_bubble", {27'd0, is_ex_unidadefuncional, is_ex_regdest != 0, is_ex_writereg, 1'b0}, 32'd0);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        id_is_valid    = 1'b0;
        id_is_addra    = '0;
        id_is_addrb    = '0;
        id_is_numop    = '0;
        id_is_regdest  = '0;
        id_is_writereg = 1'b0;
        id_is_fu       = '0;
        execute_stall  = 1'b1;
        #2;
        check("rst_pending", is_pending, 32'd0);
        check("rst_ex_valid", 32'(is_ex_valid), 32'd0);
        check("rst_if_stall", 32'(is_if_stall), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        execute_stall = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // ALU r5 then r6 <- r5: one stall cycle, issue at T+2
        present(5'd0, 5'd0, 2'd0, 5'd5, 1'b1, 2'b01, 1'b1);
        wait_issue("t2_alu_r5", 0);
        present(5'd5, 5'd0, 2'd1, 5'd6, 1'b1, 2'b01, 1'b1);
        wait_issue("t2_raw_stall", 1);

        // Back-to-back independent MULs: 4 structural stall cycles
        present(5'd1, 5'd2, 2'd2, 5'd7, 1'b1, 2'b11, 1'b1);
        wait_issue("t3_mul_r7", 0);
        present(5'd0, 5'd0, 2'd0, 5'd8, 1'b1, 2'b11, 1'b1);
        wait_issue("t3_mul_struct", 4);

        // LOAD r3 then ALU write r3: WAW holds for LAT_MEM cycles
        repeat (5) @(posedge clock);
        #1;
        present(5'd0, 5'd0, 2'd1, 5'd3, 1'b1, 2'b10, 1'b1);
        wait_issue("t4_load_r3", 0);
        present(5'd0, 5'd0, 2'd0, 5'd3, 1'b1, 2'b01, 1'b1);
        #3;
        check("t4_pend3_set", 32'(is_pending[3]), 32'd1);
        wait_issue("t4_waw_stall", 2);

        // MUL r9 with execute_stall for 3 cycles: countdown and is_ex_* frozen
        present(5'd0, 5'd0, 2'd0, 5'd9, 1'b1, 2'b11, 1'b1);
        wait_issue("t5_mul_r9", 0);
        present(5'd9, 5'd0, 2'd1, 5'd10, 1'b1, 2'b01, 1'b1);
        execute_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("t5_if_stall", 32'(is_if_stall), 32'd1);
            check("t5_hold_valid", 32'(is_ex_valid), 32'd1);
            check("t5_hold_fu", 32'(is_ex_unidadefuncional), 32'd3);
            check("t5_hold_rd", 32'(is_ex_regdest), 32'd9);
            check("t5_hold_wr", 32'(is_ex_writereg), 32'd1);
            @(posedge clock); #1;
        end
        check("t5_pend9_frozen", 32'(is_pending[9]), 32'd1);
        execute_stall = 1'b0;
        wait_issue("t5_raw_after_freeze", 4);

        // r0 never pending; numop=0 ignores sources; fu=00 never writes
        repeat (2) @(posedge clock);
        #1;
        present(5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'b01, 1'b1);
        wait_issue("t6_write_r0", 0);
        #3;
        check("t6_pend_r0", is_pending, 32'd0);
        present(5'd0, 5'd0, 2'd2, 5'd1, 1'b0, 2'b01, 1'b0);
        wait_issue("t6_read_r0", 0);
        present(5'd0, 5'd0, 2'd0, 5'd11, 1'b1, 2'b11, 1'b1);
        wait_issue("t6_mul_r11", 0);
        present(5'd11, 5'd11, 2'd0, 5'd2, 1'b1, 2'b01, 1'b1);
        wait_issue("t6_numop0", 0);
        present(5'd0, 5'd0, 2'd0, 5'd12, 1'b1, 2'b00, 1'b0);
        wait_issue("t6_fu_none", 0);
        #3;
        check("t6_pend12", 32'(is_pending[12]), 32'd0);

        // Reset mid-run with r13/r14/r15 pending
        repeat (6) @(posedge clock);
        #1;
        present(5'd0, 5'd0, 2'd0, 5'd13, 1'b1, 2'b11, 1'b1);
        wait_issue("t1_mul_r13", 0);
        present(5'd0, 5'd0, 2'd0, 5'd14, 1'b1, 2'b10, 1'b1);
        wait_issue("t1_load_r14", 0);
        present(5'd0, 5'd0, 2'd0, 5'd15, 1'b1, 2'b10, 1'b1);
        wait_issue("t1_load_r15", 0);
        @(negedge clock);
        check("t1_pend_before", is_pending, 32'h0000_E000);
        #1;
        id_is_valid   = 1'b1;
        execute_stall = 1'b1;
        reset         = 1'b1;
        #1;
        check("t1_pend_reset", is_pending, 32'd0);
        check("t1_ex_valid", 32'(is_ex_valid), 32'd0);
        check("t1_ex_fu", 32'(is_ex_unidadefuncional), 32'd0);
        check("t1_ex_rd", 32'(is_ex_regdest), 32'd0);
        check("t1_ex_wr", 32'(is_ex_writereg), 32'd0);
        check("t1_if_stall", 32'(is_if_stall), 32'd0);
        @(posedge clock); #1;
        reset         = 1'b0;
        execute_stall = 1'b0;
        id_is_valid   = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
